// File: rtl/axil_pkg.sv
// Shared response codes and address-decode helper for the AXI4-Lite register file.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Number of byte-offset address bits below the register index.
  function automatic int idx_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axil_hold_slot.sv
// One-deep valid/data holder: accepts a beat whenever empty and keeps it until cleared.
module axil_hold_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid,
  output logic         ready,
  input  logic [W-1:0] data_in,
  input  logic         clear,
  output logic         held,
  output logic [W-1:0] data
);

  assign ready = !held;

  // Clear only ever arrives while held, and a fill only while empty, so they never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      held <= 1'b0;
      data <= '0;
    end else if (clear) begin
      held <= 1'b0;
    end else if (valid && !held) begin
      held <= 1'b1;
      data <= data_in;
    end
  end

endmodule

// File: rtl/axil_regfile.sv
// AXI4-Lite slave register file with independent AW/W acceptance, read-only status
// registers, out-of-range SLVERR and per-register write pulses.
module axil_regfile
  import axil_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter int                    ADDR_WIDTH = 7,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESET,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = idx_lsb(DATA_WIDTH);
  localparam int IDXW   = ADDR_WIDTH - LSB;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                   aw_held;
  logic                   w_held;
  logic [IDXW-1:0]        aw_idx;
  logic [DATA_WIDTH-1:0]  w_data;
  logic [STRB_W-1:0]      w_strb;
  logic                   commit;
  logic                   aw_in_range;

  logic [IDXW-1:0]        ar_idx;
  logic                   ar_hs;
  logic                   ar_in_range;
  logic [DATA_WIDTH-1:0]  rd_word;

  logic                   unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, reg_in};

  axil_hold_slot #(.W(IDXW)) u_aw_slot (
    .clk     (S_AXI_ACLK),
    .reset   (S_AXI_ARESET),
    .valid   (S_AXI_AWVALID),
    .ready   (S_AXI_AWREADY),
    .data_in (S_AXI_AWADDR[ADDR_WIDTH-1:LSB]),
    .clear   (commit),
    .held    (aw_held),
    .data    (aw_idx)
  );

  axil_hold_slot #(.W(DATA_WIDTH + STRB_W)) u_w_slot (
    .clk     (S_AXI_ACLK),
    .reset   (S_AXI_ARESET),
    .valid   (S_AXI_WVALID),
    .ready   (S_AXI_WREADY),
    .data_in ({S_AXI_WSTRB, S_AXI_WDATA}),
    .clear   (commit),
    .held    (w_held),
    .data    ({w_strb, w_data})
  );

  assign commit      = aw_held && w_held && (!S_AXI_BVALID || S_AXI_BREADY);
  assign aw_in_range = {{(32-IDXW){1'b0}}, aw_idx} < 32'(NUM_REGS);

  // Read-only registers keep their storage at RESET_VAL; only the mask decides what a read sees.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      wr_pulse     <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
    end else begin
      wr_pulse <= '0;
      if (commit) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (aw_idx == IDXW'(i) && !RO_MASK[i]) begin
            wr_pulse[i] <= 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
              if (w_strb[b]) regs[i][b*8 +: 8] <= w_data[b*8 +: 8];
            end
          end
        end
      end else if (S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  assign ar_idx        = S_AXI_ARADDR[ADDR_WIDTH-1:LSB];
  assign ar_in_range   = {{(32-IDXW){1'b0}}, ar_idx} < 32'(NUM_REGS);
  assign S_AXI_ARREADY = !S_AXI_RVALID;
  assign ar_hs         = S_AXI_ARVALID && !S_AXI_RVALID;

  // Indices past NUM_REGS match nothing and fall through to zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDXW'(i)) rd_word = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RRESP  <= RESP_OKAY;
      S_AXI_RDATA  <= '0;
    end else if (ar_hs) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= rd_word;
      S_AXI_RRESP  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_regfile.sv
// Self-checking bench for axil_regfile: directed vectors, multi-cycle corner sequences
// and randomized traffic against an array-based register model.
module tb_axil_regfile;

  localparam int NR = 16;
  localparam int DW = 32;
  localparam int AW = 7;
  localparam logic [NR-1:0] RO_TB = 16'h0008;

  logic            clk = 1'b0;
  logic            areset;
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [3:0]      wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;
  logic [NR*DW-1:0] reg_out;
  logic [NR*DW-1:0] reg_in;
  logic [NR-1:0]   wr_pulse;

  int checks_total = 0;
  int checks_passed = 0;

  logic [DW-1:0] mdl [NR];

  typedef struct {
    logic          is_write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    strb;
    logic [1:0]    exp_resp;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs [14];

  axil_regfile #(
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .ADDR_WIDTH (AW),
    .RO_MASK    (RO_TB),
    .RESET_VAL  ('0)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (areset),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg_out       (reg_out),
    .reg_in        (reg_in),
    .wr_pulse      (wr_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [NR*DW-1:0] actual,
                             input logic [NR*DW-1:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NR*DW-1:0] modelFlat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = mdl[i];
    return f;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < NR; i++) mdl[i] = '0;
  endfunction

  // Word index is the byte address divided by four; anything at or past 16 is an error.
  function automatic void modelWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                     input logic [3:0] strb, output logic [1:0] resp,
                                     output logic [NR-1:0] pulse);
    int idx;
    idx = int'(addr) / 4;
    pulse = '0;
    if (idx >= NR) begin
      resp = 2'b10;
    end else begin
      resp = 2'b00;
      if (!RO_TB[idx]) begin
        pulse[idx] = 1'b1;
        for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
      end
    end
  endfunction

  function automatic void modelRead(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                                    output logic [1:0] resp);
    int idx;
    idx = int'(addr) / 4;
    if (idx >= NR) begin
      resp = 2'b10;
      data = '0;
    end else begin
      resp = 2'b00;
      data = RO_TB[idx] ? reg_in[idx*DW +: DW] : mdl[idx];
    end
  endfunction

  task automatic axiWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [3:0] strb, output logic [1:0] resp,
                          output logic [NR-1:0] pulse);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int c = 0; c < 20 && !bvalid; c++) tick();
    checkOutput("write_bvalid_seen", bvalid, 1);
    resp = bresp;
    pulse = wr_pulse;
    tick();
  endtask

  task automatic axiRead(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                         output logic [1:0] resp);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    for (int c = 0; c < 20 && !rvalid; c++) tick();
    checkOutput("read_rvalid_seen", rvalid, 1);
    data = rdata;
    resp = rresp;
    tick();
  endtask

  task automatic applyStimulus(input vec_t v, input int n);
    logic [1:0]    er, ar;
    logic [NR-1:0] ep, ap;
    logic [DW-1:0] ad;
    if (v.is_write) begin
      modelWrite(v.addr, v.data, v.strb, er, ep);
      axiWrite(v.addr, v.data, v.strb, ar, ap);
      checkOutput($sformatf("vec%0d_bresp", n), ar, v.exp_resp);
      checkOutput($sformatf("vec%0d_wr_pulse", n), ap, ep);
      checkOutput($sformatf("vec%0d_reg_out", n), reg_out, modelFlat());
    end else begin
      axiRead(v.addr, ad, ar);
      checkOutput($sformatf("vec%0d_rresp", n), ar, v.exp_resp);
      checkOutput($sformatf("vec%0d_rdata", n), ad, v.exp_data);
    end
  endtask

  initial begin
    logic [1:0]    r, er;
    logic [NR-1:0] p, ep;
    logic [DW-1:0] d, ed;
    logic [AW-1:0] a;
    int bcount;

    vecs[0]  = '{1'b1, 7'h14, 32'h12345678, 4'hF, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, 7'h14, 32'h0,        4'h0, 2'b00, 32'h12345678};
    vecs[2]  = '{1'b1, 7'h17, 32'hFFFFFFFF, 4'h1, 2'b00, 32'h0};
    vecs[3]  = '{1'b0, 7'h14, 32'h0,        4'h0, 2'b00, 32'h123456FF};
    vecs[4]  = '{1'b1, 7'h7C, 32'hABCDEF01, 4'hF, 2'b10, 32'h0};
    vecs[5]  = '{1'b0, 7'h7C, 32'h0,        4'h0, 2'b10, 32'h0};
    vecs[6]  = '{1'b1, 7'h0C, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h0};
    vecs[7]  = '{1'b0, 7'h0C, 32'h0,        4'h0, 2'b00, 32'h00005A5A};
    vecs[8]  = '{1'b1, 7'h3C, 32'hCAFEF00D, 4'h0, 2'b00, 32'h0};
    vecs[9]  = '{1'b0, 7'h3C, 32'h0,        4'h0, 2'b00, 32'h0};
    vecs[10] = '{1'b1, 7'h3C, 32'hCAFEF00D, 4'hC, 2'b00, 32'h0};
    vecs[11] = '{1'b0, 7'h3D, 32'h0,        4'h0, 2'b00, 32'hCAFE0000};
    vecs[12] = '{1'b0, 7'h40, 32'h0,        4'h0, 2'b10, 32'h0};
    vecs[13] = '{1'b0, 7'h00, 32'h0,        4'h0, 2'b00, 32'h0};

    for (int i = 0; i < NR; i++) reg_in[i*DW +: DW] = $urandom;
    reg_in[3*DW +: DW] = 32'h00005A5A;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    areset = 1'b1;
    modelReset();

    // Reset held for two cycles.
    tick(); tick();
    areset = 1'b0;
    checkOutput("t1_awready", awready, 1);
    checkOutput("t1_wready", wready, 1);
    checkOutput("t1_arready", arready, 1);
    checkOutput("t1_bvalid", bvalid, 0);
    checkOutput("t1_rvalid", rvalid, 0);
    checkOutput("t1_rdata", rdata, 0);
    checkOutput("t1_wr_pulse", wr_pulse, 0);
    checkOutput("t1_reg_out", reg_out, modelFlat());

    // Simultaneous out-of-range write and read, R channel back-pressured.
    awaddr = 7'h40; wdata = 32'h80000000; wstrb = 4'h8; araddr = 7'h44;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checkOutput("t2_rvalid", rvalid, 1);
    checkOutput("t2_rresp", rresp, 2'b10);
    checkOutput("t2_rdata", rdata, 0);
    checkOutput("t2_arready", arready, 0);
    bcount = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      bcount += int'(bvalid);
      if (bvalid) checkOutput("t2_bresp", bresp, 2'b10);
      checkOutput("t2_rvalid_held", rvalid, 1);
      checkOutput("t2_rdata_held", rdata, 0);
    end
    checkOutput("t2_bvalid_count", bcount, 1);
    rready = 1'b1;
    tick();
    checkOutput("t2_rvalid_cleared", rvalid, 0);
    checkOutput("t2_reg_out", reg_out, modelFlat());

    for (int i = 0; i < 14; i++) applyStimulus(vecs[i], i);

    // Split write: AW several cycles ahead of W.
    bready = 1'b1;
    awaddr = 7'h04; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput("t3_awready_low", awready, 0);
      checkOutput("t3_bvalid_low", bvalid, 0);
      tick();
    end
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    checkOutput("t3_bvalid_not_yet", bvalid, 0);
    tick();
    void'(modelWrite(7'h04, 32'hDEADBEEF, 4'hF, er, ep));
    checkOutput("t3_bvalid", bvalid, 1);
    checkOutput("t3_wr_pulse", wr_pulse, ep);
    checkOutput("t3_reg1", reg_out[1*DW +: DW], 32'hDEADBEEF);
    tick();
    checkOutput("t3_wr_pulse_gone", wr_pulse, 0);
    checkOutput("t3_bvalid_gone", bvalid, 0);

    // Strobed write under B back-pressure, with a second write queued behind it.
    modelWrite(7'h08, 32'h11223344, 4'hF, er, ep);
    axiWrite(7'h08, 32'h11223344, 4'hF, r, p);
    checkOutput("t4_first_bresp", r, er);
    bready = 1'b0;
    awaddr = 7'h08; wdata = 32'hAABBCCDD; wstrb = 4'h5; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    modelWrite(7'h08, 32'hAABBCCDD, 4'h5, er, ep);
    checkOutput("t4_bvalid", bvalid, 1);
    checkOutput("t4_wr_pulse", wr_pulse, ep);
    checkOutput("t4_reg2", reg_out[2*DW +: DW], 32'h11BB33DD);
    wdata = 32'h01020304; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    checkOutput("t4_awready_full", awready, 0);
    checkOutput("t4_wready_full", wready, 0);
    for (int k = 0; k < 3; k++) begin
      checkOutput("t4_bvalid_held", bvalid, 1);
      checkOutput("t4_bresp_held", bresp, 2'b00);
      checkOutput("t4_reg_out_held", reg_out, modelFlat());
      tick();
    end
    bready = 1'b1;
    tick();
    modelWrite(7'h08, 32'h01020304, 4'hF, er, ep);
    checkOutput("t4_bvalid_reissued", bvalid, 1);
    checkOutput("t4_second_pulse", wr_pulse, ep);
    checkOutput("t4_second_reg_out", reg_out, modelFlat());
    tick();
    checkOutput("t4_bvalid_done", bvalid, 0);
    checkOutput("t4_awready_back", awready, 1);

    // Read and write commit on the same edge to one register: read sees the old value.
    modelWrite(7'h18, 32'h0BADCAFE, 4'hF, er, ep);
    axiWrite(7'h18, 32'h0BADCAFE, 4'hF, r, p);
    awaddr = 7'h18; wdata = 32'h600DF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    rready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 7'h18; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    checkOutput("hz_rvalid", rvalid, 1);
    checkOutput("hz_rdata_old", rdata, 32'h0BADCAFE);
    checkOutput("hz_bvalid", bvalid, 1);
    modelWrite(7'h18, 32'h600DF00D, 4'hF, er, ep);
    checkOutput("hz_reg_out_new", reg_out, modelFlat());
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 150; n++) begin
      a = AW'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        wstrb = 4'($urandom_range(0, 15));
        modelWrite(a, d, wstrb, er, ep);
        axiWrite(a, d, wstrb, r, p);
        checkOutput($sformatf("rnd%0d_bresp", n), r, er);
        checkOutput($sformatf("rnd%0d_wr_pulse", n), p, ep);
        checkOutput($sformatf("rnd%0d_reg_out", n), reg_out, modelFlat());
      end else begin
        modelRead(a, ed, er);
        axiRead(a, d, r);
        checkOutput($sformatf("rnd%0d_rresp", n), r, er);
        checkOutput($sformatf("rnd%0d_rdata", n), d, ed);
      end
    end

    // Reset while a response is pending and an address is held.
    bready = 1'b0;
    awaddr = 7'h10; wdata = 32'h13572468; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    checkOutput("t6_bvalid_pending", bvalid, 1);
    awaddr = 7'h20; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    checkOutput("t6_aw_held", awready, 0);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    modelReset();
    checkOutput("t6_awready", awready, 1);
    checkOutput("t6_wready", wready, 1);
    checkOutput("t6_arready", arready, 1);
    checkOutput("t6_bvalid", bvalid, 0);
    checkOutput("t6_rvalid", rvalid, 0);
    checkOutput("t6_bresp", bresp, 0);
    checkOutput("t6_wr_pulse", wr_pulse, 0);
    checkOutput("t6_reg_out", reg_out, modelFlat());
    bready = 1'b1;
    wdata = 32'h24681357; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("t6_no_stale_bvalid", bvalid, 0);
      checkOutput("t6_no_stale_pulse", wr_pulse, 0);
      tick();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
